// File: rtl/data_path_pkg.sv
// Shared definitions for the single-bus datapath: word widths and ALU opcode encodings.
package data_path_pkg;

  localparam int WIDTH = 32;

  typedef logic [WIDTH-1:0]   word_t;
  typedef logic [2*WIDTH-1:0] dword_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

endpackage

// File: rtl/data_path_if.sv
// Control/observation bundle between the control unit (master) and the datapath (slave).
interface data_path_if;
  import data_path_pkg::*;

  logic  PCout, Zhighout, Zlowout, MDRout;
  logic  R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out;
  logic  MARin, PCin, MDRin, IRin, Yin, IncPC, Read;
  logic [4:0] opcode;
  logic  R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in;
  logic  R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in;
  logic  HIin, LOin, ZHighIn, ZLowIn, Cin;
  word_t Mdatain;
  word_t BusMuxOut, IRq, MARq;

  modport master (
    output PCout, Zhighout, Zlowout, MDRout,
    output R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    output MARin, PCin, MDRin, IRin, Yin, IncPC, Read, opcode,
    output R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
    output R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
    output HIin, LOin, ZHighIn, ZLowIn, Cin, Mdatain,
    input  BusMuxOut, IRq, MARq
  );

  modport slave (
    input  PCout, Zhighout, Zlowout, MDRout,
    input  R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    input  MARin, PCin, MDRin, IRin, Yin, IncPC, Read, opcode,
    input  R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
    input  R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
    input  HIin, LOin, ZHighIn, ZLowIn, Cin, Mdatain,
    output BusMuxOut, IRq, MARq
  );

endinterface

// File: rtl/data_path_alu.sv
// Combinational ALU: A = Y, B = bus, 64-bit result {high, low}.
// Define DATA_PATH_DIV_EN to build the signed divider; otherwise DIV returns 0.
module data_path_alu
  import data_path_pkg::*;
(
  input  word_t      a_i,
  input  word_t      b_i,
  input  logic       cin_i,
  input  logic [4:0] opcode_i,
  output dword_t     result_o
);

  logic [4:0]                sh;
  logic signed [WIDTH-1:0]   a_s;
  logic signed [2*WIDTH-1:0] a_x, b_x, prod;
  word_t                     rot_r, rot_l;
  dword_t                    div_res;

  assign sh    = b_i[4:0];
  assign a_s   = a_i;
  assign a_x   = {{WIDTH{a_i[WIDTH-1]}}, a_i};
  assign b_x   = {{WIDTH{b_i[WIDTH-1]}}, b_i};
  assign prod  = a_x * b_x;
  // Rotates via a doubled word so a zero shift passes A through untouched.
  assign rot_r = word_t'({a_i, a_i} >> sh);
  assign rot_l = word_t'(({a_i, a_i} << sh) >> WIDTH);

`ifdef DATA_PATH_DIV_EN
  localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  logic signed [WIDTH-1:0] b_s, quo, rem;

  assign b_s = b_i;

  always_comb begin
    quo = '0;
    rem = '0;
    if (b_s != '0) begin
      // MIN / -1 overflows; keep the wrapped quotient and a zero remainder.
      if ((a_s == S_MIN) && (b_s == '1)) begin
        quo = a_s;
      end else begin
        quo = a_s / b_s;
        rem = a_s % b_s;
      end
    end
  end

  assign div_res = {rem, quo};
`else
  assign div_res = '0;
`endif

  always_comb begin
    result_o = '0;
    case (opcode_i)
      OP_ADD:          result_o[WIDTH-1:0] = a_i + b_i + word_t'(cin_i);
      OP_SUB:          result_o[WIDTH-1:0] = a_i - b_i;
      OP_AND, OP_ANDI: result_o[WIDTH-1:0] = a_i & b_i;
      OP_OR,  OP_ORI:  result_o[WIDTH-1:0] = a_i | b_i;
      OP_ROR:          result_o[WIDTH-1:0] = rot_r;
      OP_ROL:          result_o[WIDTH-1:0] = rot_l;
      OP_SHR:          result_o[WIDTH-1:0] = a_i >> sh;
      OP_SHRA:         result_o[WIDTH-1:0] = a_s >>> sh;
      OP_SHL:          result_o[WIDTH-1:0] = a_i << sh;
      OP_ADDI:         result_o[WIDTH-1:0] = a_i + b_i;
      OP_DIV:          result_o = div_res;
      OP_MUL:          result_o = prod;
      OP_NEG:          result_o[WIDTH-1:0] = -b_i;
      OP_NOT:          result_o[WIDTH-1:0] = ~b_i;
      default:         result_o = '0;
    endcase
  end

endmodule

// File: rtl/data_path.sv
// Single-bus 32-bit CPU datapath: register file, special registers, bus mux and ALU.
// Strobes are sequenced externally; DIV availability follows DATA_PATH_DIV_EN in data_path_alu.
module data_path
  import data_path_pkg::*;
(
  input  logic       clock,
  input  logic       clear,
  data_path_if.slave bus_if
);

  word_t  regs_q [16];
  word_t  regs_d [16];
  word_t  hi_q, hi_d, lo_q, lo_d, pc_q, pc_d, ir_q, ir_d;
  word_t  mar_q, mar_d, mdr_q, mdr_d, y_q, y_d;
  dword_t z_q, z_d;
  word_t  bus;
  dword_t alu_res;
  logic [15:0] r_in;
  logic [7:0]  r_out;

  assign r_in  = {bus_if.R15in, bus_if.R14in, bus_if.R13in, bus_if.R12in,
                  bus_if.R11in, bus_if.R10in, bus_if.R9in,  bus_if.R8in,
                  bus_if.R7in,  bus_if.R6in,  bus_if.R5in,  bus_if.R4in,
                  bus_if.R3in,  bus_if.R2in,  bus_if.R1in,  bus_if.R0in};
  assign r_out = {bus_if.R7out, bus_if.R6out, bus_if.R5out, bus_if.R4out,
                  bus_if.R3out, bus_if.R2out, bus_if.R1out, bus_if.R0out};

  // Later assignments override earlier ones, so R0out ends up with top priority.
  always_comb begin
    bus = '0;
    if (bus_if.Zlowout)  bus = z_q[WIDTH-1:0];
    if (bus_if.Zhighout) bus = z_q[2*WIDTH-1:WIDTH];
    if (bus_if.MDRout)   bus = mdr_q;
    if (bus_if.PCout)    bus = pc_q;
    for (int i = 7; i >= 0; i--) begin
      if (r_out[i]) bus = regs_q[i];
    end
  end

  data_path_alu u_alu (
    .a_i      (y_q),
    .b_i      (bus),
    .cin_i    (bus_if.Cin),
    .opcode_i (bus_if.opcode),
    .result_o (alu_res)
  );

  always_comb begin
    regs_d = regs_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    pc_d   = pc_q;
    ir_d   = ir_q;
    mar_d  = mar_q;
    mdr_d  = mdr_q;
    y_d    = y_q;
    z_d    = z_q;
    for (int i = 0; i < 16; i++) begin
      if (r_in[i]) regs_d[i] = bus;
    end
    if (bus_if.HIin)  hi_d  = bus;
    if (bus_if.LOin)  lo_d  = bus;
    if (bus_if.IRin)  ir_d  = bus;
    if (bus_if.MARin) mar_d = bus;
    if (bus_if.Yin)   y_d   = bus;
    if (bus_if.MDRin) mdr_d = bus_if.Read ? bus_if.Mdatain : bus;
    if (bus_if.IncPC)     pc_d = pc_q + word_t'(1);
    else if (bus_if.PCin) pc_d = bus;
    if (bus_if.ZLowIn)  z_d[WIDTH-1:0]       = alu_res[WIDTH-1:0];
    if (bus_if.ZHighIn) z_d[2*WIDTH-1:WIDTH] = alu_res[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      regs_q <= '{default: '0};
      hi_q   <= '0;
      lo_q   <= '0;
      pc_q   <= '0;
      ir_q   <= '0;
      mar_q  <= '0;
      mdr_q  <= '0;
      y_q    <= '0;
      z_q    <= '0;
    end else begin
      regs_q <= regs_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      mar_q  <= mar_d;
      mdr_q  <= mdr_d;
      y_q    <= y_d;
      z_q    <= z_d;
    end
  end

  assign bus_if.BusMuxOut = bus;
  assign bus_if.IRq       = ir_q;
  assign bus_if.MARq      = mar_q;

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: directed scenarios plus randomized register/ALU traffic
// against a behavioural model. DIV expectations follow DATA_PATH_DIV_EN.
module tb_data_path;
  import data_path_pkg::*;

  localparam logic [31:0] A3 = 32'hA3A3_0003;
  localparam logic [31:0] A7 = 32'h7777_0007;

  logic clock = 1'b0;
  logic clear = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] mdl_r [8];

  data_path_if dif ();

  data_path dut (
    .clock  (clock),
    .clear  (clear),
    .bus_if (dif)
  );

  always #5 clock = ~clock;

  task automatic clr_all();
    dif.PCout = 0; dif.Zhighout = 0; dif.Zlowout = 0; dif.MDRout = 0;
    dif.R0out = 0; dif.R1out = 0; dif.R2out = 0; dif.R3out = 0;
    dif.R4out = 0; dif.R5out = 0; dif.R6out = 0; dif.R7out = 0;
    dif.MARin = 0; dif.PCin = 0; dif.MDRin = 0; dif.IRin = 0; dif.Yin = 0;
    dif.IncPC = 0; dif.Read = 0; dif.opcode = 5'd0; dif.Cin = 0;
    dif.R0in = 0; dif.R1in = 0; dif.R2in = 0; dif.R3in = 0;
    dif.R4in = 0; dif.R5in = 0; dif.R6in = 0; dif.R7in = 0;
    dif.R8in = 0; dif.R9in = 0; dif.R10in = 0; dif.R11in = 0;
    dif.R12in = 0; dif.R13in = 0; dif.R14in = 0; dif.R15in = 0;
    dif.HIin = 0; dif.LOin = 0; dif.ZHighIn = 0; dif.ZLowIn = 0;
    dif.Mdatain = 32'h0;
  endtask

  // Sources: 0..7 = R0..R7, 8 = PC, 9 = MDR, 10 = Zhigh, 11 = Zlow.
  task automatic set_src(input int s);
    case (s)
      0: dif.R0out = 1;  1: dif.R1out = 1;  2: dif.R2out = 1;  3: dif.R3out = 1;
      4: dif.R4out = 1;  5: dif.R5out = 1;  6: dif.R6out = 1;  7: dif.R7out = 1;
      8: dif.PCout = 1;  9: dif.MDRout = 1; 10: dif.Zhighout = 1; 11: dif.Zlowout = 1;
      default: ;
    endcase
  endtask

  task automatic set_rin(input int r);
    case (r)
      0: dif.R0in = 1;   1: dif.R1in = 1;   2: dif.R2in = 1;   3: dif.R3in = 1;
      4: dif.R4in = 1;   5: dif.R5in = 1;   6: dif.R6in = 1;   7: dif.R7in = 1;
      8: dif.R8in = 1;   9: dif.R9in = 1;   10: dif.R10in = 1; 11: dif.R11in = 1;
      12: dif.R12in = 1; 13: dif.R13in = 1; 14: dif.R14in = 1; 15: dif.R15in = 1;
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd_src(input int s, output logic [31:0] v);
    @(negedge clock);
    set_src(s);
    #1;
    v = dif.BusMuxOut;
    clr_all();
  endtask

  task automatic load_reg(input int r, input logic [31:0] v);
    @(negedge clock);
    dif.Mdatain = v; dif.Read = 1; dif.MDRin = 1;
    tick(); clr_all();
    dif.MDRout = 1; set_rin(r);
    tick(); clr_all();
    if (r < 8) mdl_r[r] = v;
  endtask

  task automatic run_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic cin);
    load_reg(1, a);
    @(negedge clock);
    dif.R1out = 1; dif.Yin = 1;
    tick(); clr_all();
    load_reg(2, b);
    @(negedge clock);
    dif.R2out = 1; dif.opcode = op; dif.Cin = cin; dif.ZLowIn = 1; dif.ZHighIn = 1;
    tick(); clr_all();
  endtask

  // Reference ALU built from the operation definitions with plain arithmetic and bit loops.
  function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin);
    longint sa, sb, q, rm;
    logic [31:0] lo, hi, t;
    int n;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    n  = int'(b[4:0]);
    lo = 32'h0; hi = 32'h0; t = a;
    q = 0; rm = 0;
    case (op)
      5'd3:  lo = a + b + {31'b0, cin};
      5'd4:  lo = a - b;
      5'd5, 5'd13: lo = a & b;
      5'd6, 5'd14: lo = a | b;
      5'd7:  begin for (int i = 0; i < n; i++) t = {t[0], t[31:1]};   lo = t; end
      5'd8:  begin for (int i = 0; i < n; i++) t = {t[30:0], t[31]};  lo = t; end
      5'd9:  begin for (int i = 0; i < n; i++) t = {1'b0, t[31:1]};   lo = t; end
      5'd10: begin for (int i = 0; i < n; i++) t = {t[31], t[31:1]};  lo = t; end
      5'd11: begin for (int i = 0; i < n; i++) t = {t[30:0], 1'b0};   lo = t; end
      5'd12: lo = a + b;
      5'd15: begin
`ifdef DATA_PATH_DIV_EN
        if (b != 32'h0) begin
          q = sa / sb; rm = sa % sb;
          lo = q[31:0]; hi = rm[31:0];
        end
`endif
      end
      5'd16: begin q = sa * sb; lo = q[31:0]; hi = q[63:32]; end
      5'd17: lo = 32'h0 - b;
      5'd18: lo = ~b;
      default: ;
    endcase
    return {hi, lo};
  endfunction

  task automatic test_reset();
    logic [31:0] v;
    #1 clear = 0;
    #2;
    vectors++; if (dif.IRq !== 32'h0) begin miscompares++; $display("FAIL reset_ir: got %h want %h", dif.IRq, 32'h0); end
    vectors++; if (dif.MARq !== 32'h0) begin miscompares++; $display("FAIL reset_mar: got %h want %h", dif.MARq, 32'h0); end
    vectors++; if (dif.BusMuxOut !== 32'h0) begin miscompares++; $display("FAIL reset_idle_bus: got %h want %h", dif.BusMuxOut, 32'h0); end
    @(posedge clock);
    @(negedge clock);
    clear = 1;
    for (int s = 0; s < 12; s++) begin
      rd_src(s, v);
      vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL reset_src%0d: got %h want %h", s, v, 32'h0); end
    end
  endtask

  task automatic test_pc_mar();
    logic [31:0] v;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      dif.PCout = 1; dif.MARin = 1; dif.IncPC = 1;
      #1;
      vectors++; if (dif.BusMuxOut !== 32'(k)) begin miscompares++; $display("FAIL pc_old_on_bus: got %h want %h", dif.BusMuxOut, 32'(k)); end
      tick(); clr_all();
      vectors++; if (dif.MARq !== 32'(k)) begin miscompares++; $display("FAIL mar_from_pc: got %h want %h", dif.MARq, 32'(k)); end
      rd_src(8, v);
      vectors++; if (v !== 32'(k + 1)) begin miscompares++; $display("FAIL pc_inc: got %h want %h", v, 32'(k + 1)); end
    end
  endtask

  task automatic test_mdr_load();
    logic [31:0] v;
    load_reg(0, 32'h12);
    load_reg(5, 32'h7F);
    rd_src(0, v);
    vectors++; if (v !== 32'h12) begin miscompares++; $display("FAIL mdr_load_r0: got %h want %h", v, 32'h12); end
    rd_src(5, v);
    vectors++; if (v !== 32'h7F) begin miscompares++; $display("FAIL mdr_load_r5: got %h want %h", v, 32'h7F); end
  endtask

  task automatic test_neg();
    logic [31:0] v;
    @(negedge clock);
    dif.R0out = 1; dif.opcode = OP_NEG; dif.ZLowIn = 1;
    tick(); clr_all();
    rd_src(11, v);
    vectors++; if (v !== 32'hFFFF_FFEE) begin miscompares++; $display("FAIL neg_zlow: got %h want %h", v, 32'hFFFF_FFEE); end
    @(negedge clock);
    dif.Zlowout = 1; dif.R5in = 1;
    tick(); clr_all();
    rd_src(5, v);
    vectors++; if (v !== 32'hFFFF_FFEE) begin miscompares++; $display("FAIL neg_to_r5: got %h want %h", v, 32'hFFFF_FFEE); end
  endtask

  task automatic test_add_carry();
    logic [31:0] v;
    load_reg(5, 32'h7F);
    @(negedge clock);
    dif.R0out = 1; dif.Yin = 1;
    tick(); clr_all();
    @(negedge clock);
    dif.R5out = 1; dif.opcode = OP_ADD; dif.Cin = 1; dif.ZLowIn = 1; dif.ZHighIn = 1;
    tick(); clr_all();
    rd_src(11, v);
    vectors++; if (v !== 32'h92) begin miscompares++; $display("FAIL add_cin_low: got %h want %h", v, 32'h92); end
    rd_src(10, v);
    vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL add_cin_high: got %h want %h", v, 32'h0); end
  endtask

  task automatic test_mul();
    logic [31:0] hi, lo;
    run_alu(OP_MUL, 32'hFFFF_FFFE, 32'h3, 1'b0);
    rd_src(10, hi); rd_src(11, lo);
    vectors++; if (hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL mul_high: got %h want %h", hi, 32'hFFFF_FFFF); end
    vectors++; if (lo !== 32'hFFFF_FFFA) begin miscompares++; $display("FAIL mul_low: got %h want %h", lo, 32'hFFFF_FFFA); end
    // Y still holds -2 and R2 holds 3: load only one half of Z at a time.
    @(negedge clock);
    dif.R2out = 1; dif.opcode = OP_ADD; dif.ZLowIn = 1;
    tick(); clr_all();
    rd_src(10, hi); rd_src(11, lo);
    vectors++; if (hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL zlow_only_high_kept: got %h want %h", hi, 32'hFFFF_FFFF); end
    vectors++; if (lo !== 32'h1) begin miscompares++; $display("FAIL zlow_only_low: got %h want %h", lo, 32'h1); end
    @(negedge clock);
    dif.R2out = 1; dif.opcode = OP_ADD; dif.ZHighIn = 1;
    tick(); clr_all();
    rd_src(10, hi); rd_src(11, lo);
    vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL zhigh_only_high: got %h want %h", hi, 32'h0); end
    vectors++; if (lo !== 32'h1) begin miscompares++; $display("FAIL zhigh_only_low_kept: got %h want %h", lo, 32'h1); end
  endtask

  task automatic test_div();
    logic [31:0] hi, lo, eh, el;
`ifdef DATA_PATH_DIV_EN
    eh = 32'h1; el = 32'h7;
`else
    eh = 32'h0; el = 32'h0;
`endif
    run_alu(OP_DIV, 32'h7F, 32'h12, 1'b0);
    rd_src(10, hi); rd_src(11, lo);
    vectors++; if (hi !== eh) begin miscompares++; $display("FAIL div_rem: got %h want %h", hi, eh); end
    vectors++; if (lo !== el) begin miscompares++; $display("FAIL div_quo: got %h want %h", lo, el); end
`ifdef DATA_PATH_DIV_EN
    eh = 32'hFFFF_FFFF; el = 32'hFFFF_FFFD;
`endif
    run_alu(OP_DIV, 32'hFFFF_FFF9, 32'h2, 1'b0);
    rd_src(10, hi); rd_src(11, lo);
    vectors++; if (hi !== eh) begin miscompares++; $display("FAIL div_neg_rem: got %h want %h", hi, eh); end
    vectors++; if (lo !== el) begin miscompares++; $display("FAIL div_neg_quo: got %h want %h", lo, el); end
    run_alu(OP_MUL, 32'h5, 32'h7, 1'b0);
    run_alu(OP_DIV, 32'h1234, 32'h0, 1'b0);
    rd_src(10, hi); rd_src(11, lo);
    vectors++; if ({hi, lo} !== 64'h0) begin miscompares++; $display("FAIL div_by_zero: got %h want %h", {hi, lo}, 64'h0); end
  endtask

  task automatic test_pc_wrap();
    logic [31:0] v;
    load_reg(1, 32'hFFFF_FFFF);
    @(negedge clock);
    dif.R1out = 1; dif.PCin = 1;
    tick(); clr_all();
    rd_src(8, v);
    vectors++; if (v !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL pc_load: got %h want %h", v, 32'hFFFF_FFFF); end
    @(negedge clock);
    dif.IncPC = 1;
    tick(); clr_all();
    rd_src(8, v);
    vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL pc_wrap: got %h want %h", v, 32'h0); end
    @(negedge clock);
    dif.IncPC = 1; dif.PCin = 1; dif.R1out = 1;
    tick(); clr_all();
    rd_src(8, v);
    vectors++; if (v !== 32'h1) begin miscompares++; $display("FAIL incpc_over_pcin: got %h want %h", v, 32'h1); end
  endtask

  task automatic test_bus_priority();
    logic [5:0]  masks [6];
    logic [31:0] expv  [6];
    longint p;
    load_reg(3, A3);
    load_reg(7, A7);
    @(negedge clock);
    dif.R3out = 1; dif.Yin = 1;
    tick(); clr_all();
    @(negedge clock);
    dif.R7out = 1; dif.opcode = OP_MUL; dif.ZLowIn = 1; dif.ZHighIn = 1;
    tick(); clr_all();
    @(negedge clock);
    dif.R3out = 1; dif.PCin = 1;
    tick(); clr_all();
    @(negedge clock);
    dif.IncPC = 1;
    tick(); clr_all();
    @(negedge clock);
    dif.Mdatain = 32'h0DD0_1234; dif.Read = 1; dif.MDRin = 1;
    tick(); clr_all();
    p = longint'($signed(A3)) * longint'($signed(A7));
    // mask bits: R3out, R7out, PCout, MDRout, Zhighout, Zlowout
    masks[0] = 6'b111111; expv[0] = A3;
    masks[1] = 6'b011111; expv[1] = A7;
    masks[2] = 6'b001111; expv[2] = A3 + 32'h1;
    masks[3] = 6'b000111; expv[3] = 32'h0DD0_1234;
    masks[4] = 6'b000011; expv[4] = p[63:32];
    masks[5] = 6'b000001; expv[5] = p[31:0];
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      {dif.R3out, dif.R7out, dif.PCout, dif.MDRout, dif.Zhighout, dif.Zlowout} = masks[i];
      #1;
      vectors++; if (dif.BusMuxOut !== expv[i]) begin miscompares++; $display("FAIL bus_priority%0d: got %h want %h", i, dif.BusMuxOut, expv[i]); end
      clr_all();
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] v;
    @(negedge clock);
    dif.MDRout = 1; dif.Read = 1; dif.MDRin = 1; dif.Mdatain = 32'hCAFE_F00D;
    #1;
    vectors++; if (dif.BusMuxOut !== 32'h0DD0_1234) begin miscompares++; $display("FAIL mdr_old_on_bus: got %h want %h", dif.BusMuxOut, 32'h0DD0_1234); end
    tick(); clr_all();
    rd_src(9, v);
    vectors++; if (v !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL mdr_new_after_edge: got %h want %h", v, 32'hCAFE_F00D); end
    @(negedge clock);
    dif.R3out = 1; dif.IRin = 1; dif.MARin = 1;
    tick(); clr_all();
    vectors++; if (dif.IRq !== A3) begin miscompares++; $display("FAIL ir_load: got %h want %h", dif.IRq, A3); end
    vectors++; if (dif.MARq !== A3) begin miscompares++; $display("FAIL mar_load: got %h want %h", dif.MARq, A3); end
  endtask

  task automatic test_regfile_random();
    logic [31:0] v, got;
    int r, s;
    for (int i = 0; i < 8; i++) load_reg(i, $urandom);
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 15);
      v = $urandom;
      load_reg(r, v);
      s = $urandom_range(0, 7);
      rd_src(s, got);
      vectors++; if (got !== mdl_r[s]) begin miscompares++; $display("FAIL regfile_r%0d: got %h want %h", s, got, mdl_r[s]); end
    end
  endtask

  task automatic test_alu_random();
    logic [4:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        cin;
    logic [63:0] e;
    for (int k = 0; k < 300; k++) begin
      op  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(3, 18));
      a   = $urandom;
      b   = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      cin = 1'($urandom_range(0, 1));
      run_alu(op, a, b, cin);
      e = ref_alu(op, a, b, cin);
      rd_src(10, hi); rd_src(11, lo);
      vectors++;
      if ({hi, lo} !== e) begin
        miscompares++;
        $display("FAIL alu op=%0d a=%h b=%h cin=%0d: got %h want %h", op, a, b, cin, {hi, lo}, e);
      end
    end
  endtask

  task automatic test_clear_mid();
    logic [31:0] v;
    load_reg(0, 32'h5555_AAAA);
    @(negedge clock);
    #2 clear = 0;
    #1;
    vectors++; if (dif.IRq !== 32'h0) begin miscompares++; $display("FAIL clear_ir: got %h want %h", dif.IRq, 32'h0); end
    vectors++; if (dif.MARq !== 32'h0) begin miscompares++; $display("FAIL clear_mar: got %h want %h", dif.MARq, 32'h0); end
    for (int s = 0; s < 12; s++) begin
      set_src(s);
      #1;
      vectors++; if (dif.BusMuxOut !== 32'h0) begin miscompares++; $display("FAIL clear_src%0d: got %h want %h", s, dif.BusMuxOut, 32'h0); end
      clr_all();
    end
    @(negedge clock);
    clear = 1;
    rd_src(0, v);
    vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL clear_r0_after: got %h want %h", v, 32'h0); end
  endtask

  initial begin
    clr_all();
    for (int i = 0; i < 8; i++) mdl_r[i] = 32'h0;
    test_reset();
    test_pc_mar();
    test_mdr_load();
    test_neg();
    test_add_carry();
    test_mul();
    test_div();
    test_pc_wrap();
    test_bus_priority();
    test_same_cycle();
    test_regfile_random();
    test_alu_random();
    test_clear_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_path.md
Name: data_path

Overview:
- Single-bus 32-bit CPU datapath for the team's RISC processor.
- Holds a general register file, special registers and an ALU.
- All transfers use one shared bus, driven by a one-hot set of *out strobes and sampled by *in strobes.
- The external control unit, or a bench, sequences the strobes; no internal FSM.

Parameters:
- WIDTH, 32, data/bus width (fixed at 32; not re-parameterised elsewhere).

Ports:
- clock  in  1  rising-edge system clock
- clear  in  1  asynchronous active-low reset; every register is zeroed while low
- PCout, Zhighout, Zlowout, MDRout  in  1 each  bus drive strobes
- R0out..R7out  in  1 each  bus drive strobes (R8–R15 are not bus-readable)
- MARin, PCin, MDRin, IRin, Yin  in  1 each  register load enables
- IncPC  in  1  PC increment
- Read  in  1  MDR input select: 1 = Mdatain, 0 = bus
- opcode  in  5  ALU operation select
- R0in..R15in  in  1 each  register load enables
- HIin, LOin  in  1 each  HI/LO load enables
- ZHighIn, ZLowIn  in  1 each  Z[63:32] / Z[31:0] load enables
- Cin  in  1  ALU carry-in (ADD only)
- Mdatain  in  32  memory read data
- BusMuxOut  out  32  current bus value (observation)
- IRq  out  32  instruction register contents
- MARq  out  32  memory address register contents

Behaviour:
- Registers: R0–R15, HI, LO, PC, IR, MAR, MDR, Y (32-bit each) and Z (64-bit).
- All registers: reset to 0 asynchronously on clear=0; otherwise update on the rising clock edge when enabled.
- Bus is combinational.
  - Priority when several strobes are high: R0out..R7out, PCout, MDRout, Zhighout, Zlowout (first listed wins).
  - No strobe high: bus = 0.
- Rn/HI/LO/IR/MAR/Y: load the bus when their *in is high.
- MDR: on MDRin, loads (Read ? Mdatain : bus).
- PC: IncPC loads PC+1 (wraps 0xFFFFFFFF→0) and takes priority over PCin; otherwise PCin loads the bus.
- ALU is combinational. A = Y, B = bus. Result is 64-bit with a 32-bit high half and 32-bit low half.
  - Only MUL and DIV produce a nonzero high half; every other op sets high = 0.
  - 00011 ADD: A+B+Cin
  - 00100 SUB: A−B
  - 00101 AND
  - 00110 OR
  - 00111 ROR: A rotated right by B[4:0]
  - 01000 ROL
  - 01001 SHR: logical right
  - 01010 SHRA: arithmetic right
  - 01011 SHL
  - 01100 ADDI: A+B
  - 01101 ANDI
  - 01110 ORI
  - 01111 DIV: signed; low = quotient, high = remainder (remainder takes the dividend's sign); B=0 gives 0/0
  - 10000 MUL: signed 32×32→64, high/low split
  - 10001 NEG: two's complement of B (unary, Y ignored)
  - 10010 NOT: ~B (unary)
  - All other codes (incl. 00000–00010): result 0.
- Shift amounts use B[4:0] only; shift of 0 passes A unchanged.
- ZLowIn latches ALU result[31:0]; ZHighIn latches result[63:32]; the two enables are independent.
- Simultaneous load and bus read of the same register: the bus shows the old value; the new value appears after the edge.
- clear asserted mid-sequence: immediate zeroing of all state, independent of clock.
- All strobes are level-sensitive at the clock edge; hold time is the bench's responsibility.

Optional Feature:
- DATA_PATH_DIV_EN
  - Defined: divider is instantiated and DIV behaves as above.
  - Undefined: no divider logic; opcode 01111 yields result 0 (both halves).

Decomposition:
- Shared package `data_path_pkg` holds the opcode localparams (OP_ADD … OP_NOT) and WIDTH.
- Natural sub-module: `data_path_alu` (combinational A, B, Cin, opcode → 64-bit result).
- Register file and bus mux stay in the top.

Test Plan:
- Load via MDR: Mdatain=0x12, Read+MDRin, then MDRout+R0in → R0=0x12; likewise R5=0x7F.
- NEG: R0=0x12; R0out+opcode=10001+ZLowIn → Zlow=0xFFFFFFEE; then Zlowout+R5in → R5=0xFFFFFFEE.
- ADD with carry: R0out+Yin (Y=0x12); R5out (0x7F), opcode 00011, Cin=1, ZLowIn → Zlow=0x92.
- MUL: Y=0xFFFFFFFE, bus=0x3 → after ZHighIn/ZLowIn, Zhigh=0xFFFFFFFF, Zlow=0xFFFFFFFA.
  - With DATA_PATH_DIV_EN, DIV 0x7F/0x12 → Zlow=0x7, Zhigh=0x1.
- PC/MAR: PCout+MARin+IncPC from reset → MAR=0, PC=1.
  - PC=0xFFFFFFFF plus IncPC → PC=0.
- Reset: registers loaded nonzero, then clear=0 between edges → all registers, IRq and MARq read 0 immediately.
